pwm_multi_gen: RTL and testbench

PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

---
 rtl/pwm_multi_gen.sv | 142 ++++++++++++++
 tb/tb_pwm_multi_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaler and period counter (edge or center
// aligned), per-channel shadowed duty registers adjusted by synchronized buttons.
module pwm_lane #(
    parameter int CNT_W = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0] MAX_X  = (CNT_W+1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] shadow, active;
    logic [CNT_W:0]   inc_sum;

    assign inc_sum = {1'b0, shadow} + STEP_X;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            // Saturating updates; simultaneous inc/dec cancel out
            if (inc && !dec)
                shadow <= (inc_sum > MAX_X) ? MAX_X[CNT_W-1:0] : inc_sum[CNT_W-1:0];
            else if (dec && !inc)
                shadow <= ({1'b0, shadow} < STEP_X) ? '0 : shadow - STEP_X[CNT_W-1:0];
            if (load)
                active <= shadow;
            pwm <= ena && (cnt < active);
        end
    end
endmodule

module pwm_multi_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 6,
    parameter int STEP  = 1,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             increase_duty,
    input  logic             decrease_duty,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [DIV_W-1:0] divisor,
    input  logic             center_mode,
    output logic [N_CH-1:0]  pwm_out,
    output logic             period_tick
);
    localparam logic       UP  = 1'b0;
    localparam logic       DOWN = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);

    logic [2:0]       inc_sync, dec_sync;
    logic             inc_ev, dec_ev;
    logic [DIV_W-1:0] pre_cnt, div_lat, div_eff;
    logic             tick, period_start;
    logic [CNT_W-1:0] cnt;
    logic             state, mode;

    // Two synchronizer flops plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_sync <= '0;
            dec_sync <= '0;
        end else begin
            inc_sync <= {inc_sync[1:0], increase_duty};
            dec_sync <= {dec_sync[1:0], decrease_duty};
        end
    end

    assign inc_ev = ena && inc_sync[1] && !inc_sync[2];
    assign dec_ev = ena && dec_sync[1] && !dec_sync[2];

    // Divisor is taken live at the start of each prescaler cycle, then held
    assign div_eff = (pre_cnt == '0) ? divisor : div_lat;
    assign tick    = ena && (pre_cnt == div_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            div_lat <= '0;
        end else if (ena) begin
            if (pre_cnt == '0)
                div_lat <= divisor;
            pre_cnt <= tick ? '0 : pre_cnt + DIV_W'(1);
        end
    end

    // Period starts on the tick that moves the counter into 0
    assign period_start = tick && (mode ? (state == DOWN && cnt == CNT_W'(1))
                                        : (cnt == CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            state       <= UP;
            mode        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= period_start;
            if (tick) begin
                if (!mode)
                    cnt <= cnt + CNT_W'(1);
                else if (state == UP) begin
                    if (cnt == CNT_MAX) state <= DOWN;
                    else                cnt   <= cnt + CNT_W'(1);
                end else begin
                    if (cnt == '0) state <= UP;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                if (period_start) begin
                    mode <= center_mode;
                    if (center_mode != mode) state <= UP;
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        pwm_lane #(.CNT_W(CNT_W), .STEP(STEP)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .inc  (inc_ev && ch_sel == SEL_W'(i)),
            .dec  (dec_ev && ch_sel == SEL_W'(i)),
            .load (period_start),
            .cnt  (cnt),
            .pwm  (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen with N_CH=2, CNT_W=4: duty stepping, saturation,
// prescaler, center mode, button corner cases, ena freeze and mid-period reset.
module tb_pwm_multi_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       increase_duty = 1'b0;
    logic       decrease_duty = 1'b0;
    logic [0:0] ch_sel = '0;
    logic [5:0] divisor = '0;
    logic       center_mode = 1'b0;
    logic [1:0] pwm_out;
    logic       period_tick;

    int vec = 0;
    int bad = 0;
    int sp, h0, h1;
    logic [63:0] pat0;

    pwm_multi_gen #(.N_CH(2), .CNT_W(4), .DIV_W(6), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .increase_duty(increase_duty), .decrease_duty(decrease_duty),
        .ch_sel(ch_sel), .divisor(divisor), .center_mode(center_mode),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic press(input logic inc, input logic dec, input int hold);
        @(negedge clk);
        increase_duty = inc;
        decrease_duty = dec;
        repeat (hold) @(negedge clk);
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic presses(input logic inc, input int n);
        for (int i = 0; i < n; i++) press(inc, !inc, 3);
    endtask

    // One full period between period_tick pulses; pwm lags the counter by one cycle
    task automatic measure(output int spacing, output int hi0, output int hi1,
                           output logic [63:0] p0);
        int n;
        n = 0; spacing = 0; hi0 = 0; hi1 = 0; p0 = '0;
        while (period_tick !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            vec++; bad++;
            $display("FAIL tick_timeout: no period_tick within %0d cycles", n);
        end
        do begin
            @(negedge clk);
            if (spacing < 64) p0[spacing] = pwm_out[0];
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            spacing++;
        end while (period_tick !== 1'b1 && spacing < 300);
    endtask

    task automatic release_and_first_tick(input string name);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (period_tick !== 1'b1 && n < 100);
        vec++;
        if (n !== 16) begin bad++; $display("FAIL %s: first period_tick after %0d cycles, want 16", name, n); end
    endtask

    task automatic test_reset();
        ena = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if (pwm_out !== 2'b00 || period_tick !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: pwm=%b tick=%b want 00/0", pwm_out, period_tick);
        end
        release_and_first_tick("reset_first_tick");
    endtask

    task automatic test_edge();
        ch_sel = 1'b0;
        presses(1'b1, 5);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (sp !== 16) begin bad++; $display("FAIL edge_period: got %0d want 16", sp); end
        vec++; if (h0 !== 5) begin bad++; $display("FAIL edge_hi0: got %0d want 5", h0); end
        vec++; if (h1 !== 0) begin bad++; $display("FAIL edge_hi1: got %0d want 0", h1); end
        vec++; if (pat0[15:0] !== 16'h001F) begin bad++; $display("FAIL edge_pattern: got %h want 001f", pat0[15:0]); end
    endtask

    task automatic test_saturate();
        ch_sel = 1'b1;
        presses(1'b1, 20);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h1 !== 15) begin bad++; $display("FAIL sat_hi_max: got %0d want 15", h1); end
        vec++; if (h0 !== 5) begin bad++; $display("FAIL sat_ch0_kept: got %0d want 5", h0); end
        presses(1'b0, 20);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h1 !== 0) begin bad++; $display("FAIL sat_hi_min: got %0d want 0", h1); end
    endtask

    task automatic test_divisor();
        ch_sel = 1'b0;
        presses(1'b1, 3);
        divisor = 6'd3;
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (sp !== 64) begin bad++; $display("FAIL div_period: got %0d want 64", sp); end
        vec++; if (h0 !== 32) begin bad++; $display("FAIL div_hi0: got %0d want 32", h0); end
    endtask

    task automatic test_center();
        divisor = 6'd0;
        center_mode = 1'b1;
        ch_sel = 1'b0;
        presses(1'b0, 4);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (sp !== 32) begin bad++; $display("FAIL ctr_period: got %0d want 32", sp); end
        vec++; if (h0 !== 8) begin bad++; $display("FAIL ctr_hi0: got %0d want 8", h0); end
        vec++;
        if (pat0[0] !== 1'b1 || pat0[31] !== 1'b1 || pat0[15] !== 1'b0) begin
            bad++; $display("FAIL ctr_centered: got first=%b last=%b mid=%b want 1 1 0", pat0[0], pat0[31], pat0[15]);
        end
    endtask

    task automatic test_back_to_back();
        press(1'b1, 1'b1, 4);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h0 !== 8) begin bad++; $display("FAIL both_buttons: got %0d want 8", h0); end
        press(1'b1, 1'b0, 100);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h0 !== 10) begin bad++; $display("FAIL held_press: got %0d want 10", h0); end
    endtask

    task automatic test_ena();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        increase_duty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pwm_out !== 2'b00 || period_tick !== 1'b0) seen = 1'b1;
        end
        increase_duty = 1'b0;
        repeat (6) @(negedge clk);
        vec++; if (seen !== 1'b0) begin bad++; $display("FAIL ena_low_outputs: activity=%b want 0", seen); end
        ena = 1'b1;
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h0 !== 10 || sp !== 32) begin bad++; $display("FAIL ena_resume: hi0=%0d period=%0d want 10/32", h0, sp); end
    endtask

    task automatic test_reset_mid();
        int n;
        center_mode = 1'b0;
        presses(1'b1, 2);
        measure(sp, h0, h1, pat0);
        measure(sp, h0, h1, pat0);
        vec++; if (h0 !== 7 || sp !== 16) begin bad++; $display("FAIL pre_reset_duty: hi0=%0d period=%0d want 7/16", h0, sp); end
        n = 0;
        while (pwm_out[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (pwm_out !== 2'b00 || period_tick !== 1'b0 || n >= 100) begin
            bad++; $display("FAIL async_reset: pwm=%b tick=%b waited=%0d want 00/0", pwm_out, period_tick, n);
        end
        repeat (2) @(negedge clk);
        release_and_first_tick("reset_mid_first_tick");
        measure(sp, h0, h1, pat0);
        vec++; if (h0 !== 0 || h1 !== 0) begin bad++; $display("FAIL post_reset_duty: hi0=%0d hi1=%0d want 0/0", h0, h1); end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_saturate();
        test_divisor();
        test_center();
        test_back_to_back();
        test_ena();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
